// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port indices.
// Port 0 is instruction fetch, port 1 is data load/store.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_PORT_IMEM = 0;
  localparam int ARB_PORT_DMEM = 1;
  localparam int NUM_ARB_PORTS = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner pick from pending requests; one-hot grant, 0 latency, no backpressure.
// MEM_PORT_ARB_RR_EN selects round-robin against the last winner; otherwise port 1 always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_ARB_PORTS-1:0] valid,
`ifdef MEM_PORT_ARB_RR_EN
  input  logic                     last,
`endif
  output logic [NUM_ARB_PORTS-1:0] grant
);

`ifdef MEM_PORT_ARB_RR_EN
  always_comb begin
    grant = valid;
    // On a tie the port that did not win last time goes first.
    if (&valid) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    grant = valid;
    if (valid[ARB_PORT_DMEM]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port slave between fetch (port 0) and data (port 1); 1-cycle grant latency
// plus slave latency, one idle bubble between transfers. MEM_PORT_ARB_RR_EN enables round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s0_valid_i,
  output logic                    s0_ready_o,
  input  logic [ADDR_WIDTH-1:0]   s0_addr_i,
  input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s0_we_i,
  output logic [DATA_WIDTH-1:0]   s0_rdata_o,

  input  logic                    s1_valid_i,
  output logic                    s1_ready_o,
  input  logic [ADDR_WIDTH-1:0]   s1_addr_i,
  input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s1_we_i,
  output logic [DATA_WIDTH-1:0]   s1_rdata_o,

  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_we_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,

  output logic [1:0]              grant_o
);

  arb_state_e                 state_q, state_d;
  logic [NUM_ARB_PORTS-1:0]   grant_q, grant_d;
  logic [NUM_ARB_PORTS-1:0]   req_vld;
  logic [NUM_ARB_PORTS-1:0]   pick_grant;

  assign req_vld = {s1_valid_i, s0_valid_i};

`ifdef MEM_PORT_ARB_RR_EN
  logic last_q, last_d;

  mem_arb_pick u_pick (
    .valid (req_vld),
    .last  (last_q),
    .grant (pick_grant)
  );
`else
  mem_arb_pick u_pick (
    .valid (req_vld),
    .grant (pick_grant)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_vld) begin
          state_d = ARB_BUSY;
          grant_d = pick_grant;
`ifdef MEM_PORT_ARB_RR_EN
          last_d  = pick_grant[ARB_PORT_DMEM];
`endif
        end
      end
      ARB_BUSY: begin
        // The granted port is served even if it drops valid mid-transfer.
        if (m_ready_i) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  // Grant is non-zero only in BUSY, so it alone qualifies every slave-side output.
  always_comb begin
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_we_o    = '0;
    if (grant_q[ARB_PORT_DMEM]) begin
      m_addr_o  = s1_addr_i;
      m_wdata_o = s1_wdata_i;
      m_we_o    = s1_we_i;
    end else if (grant_q[ARB_PORT_IMEM]) begin
      m_addr_o  = s0_addr_i;
      m_wdata_o = s0_wdata_i;
      m_we_o    = s0_we_i;
    end
  end

  assign m_valid_o  = |grant_q;
  assign s0_ready_o = grant_q[ARB_PORT_IMEM] & m_ready_i;
  assign s1_ready_o = grant_q[ARB_PORT_DMEM] & m_ready_i;
  assign s0_rdata_o = m_rdata_i;
  assign s1_rdata_o = m_rdata_i;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus a continuous-contention run.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  localparam logic [31:0] S0_ADDR  = 32'h0000_0100;
  localparam logic [31:0] S0_WDATA = 32'h0BAD_F00D;
  localparam logic [3:0]  S0_WE    = 4'h0;
  localparam logic [31:0] S1_ADDR  = 32'h0000_0200;
  localparam logic [31:0] S1_WDATA = 32'h55AA_00FF;
  localparam logic [3:0]  S1_WE    = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_addr = S0_ADDR, s0_wdata = S0_WDATA;
  logic [31:0] s1_addr = S1_ADDR, s1_wdata = S1_WDATA;
  logic [3:0]  s0_we = S0_WE, s1_we = S1_WE;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = 32'h0;
  logic [3:0]  m_we;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .s0_valid_i (s0_valid),
    .s0_ready_o (s0_ready),
    .s0_addr_i  (s0_addr),
    .s0_wdata_i (s0_wdata),
    .s0_we_i    (s0_we),
    .s0_rdata_o (s0_rdata),
    .s1_valid_i (s1_valid),
    .s1_ready_o (s1_ready),
    .s1_addr_i  (s1_addr),
    .s1_wdata_i (s1_wdata),
    .s1_we_i    (s1_we),
    .s1_rdata_o (s1_rdata),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_we_o     (m_we),
    .m_rdata_i  (m_rdata),
    .grant_o    (grant)
  );

  typedef struct {
    logic        rst;
    logic        s0v;
    logic        s1v;
    logic        mrdy;
    logic [31:0] rdata;
    logic [1:0]  e_grant;
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(logic r, logic a, logic b, logic m, logic [31:0] d,
                               logic [1:0] g, logic e0, logic e1);
    vec_t v;
    v.rst = r; v.s0v = a; v.s1v = b; v.mrdy = m; v.rdata = d;
    v.e_grant = g; v.e_r0 = e0; v.e_r1 = e1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, expv);
    end
  endtask

  initial begin
    int done, c0, c1, port, exp_port;
    logic [31:0] rd;

    // Cycle-by-cycle table; outputs checked mid-cycle after the inputs are applied.
    vecs[0]  = mkv(1, 0, 0, 0, 32'h0,        2'b00, 0, 0); // reset state
    vecs[1]  = mkv(0, 1, 0, 0, 32'h0,        2'b00, 0, 0); // port 0 read request
    vecs[2]  = mkv(0, 1, 0, 0, 32'h0,        2'b01, 0, 0);
    vecs[3]  = mkv(0, 1, 0, 0, 32'h0,        2'b01, 0, 0);
    vecs[4]  = mkv(0, 1, 0, 1, 32'hDEADBEEF, 2'b01, 1, 0);
    vecs[5]  = mkv(0, 0, 0, 0, 32'h0,        2'b00, 0, 0);
    vecs[6]  = mkv(0, 1, 1, 0, 32'h0,        2'b00, 0, 0); // simultaneous requests
    vecs[7]  = mkv(0, 1, 1, 1, 32'hCAFEF00D, 2'b10, 0, 1);
    vecs[8]  = mkv(0, 1, 0, 0, 32'h0,        2'b00, 0, 0); // bubble, loser waiting
    vecs[9]  = mkv(0, 1, 0, 0, 32'h0,        2'b01, 0, 0);
    vecs[10] = mkv(0, 1, 0, 1, 32'h12345678, 2'b01, 1, 0);
    vecs[11] = mkv(0, 0, 0, 1, 32'hFFFF0000, 2'b00, 0, 0); // stray slave ready
    vecs[12] = mkv(0, 0, 0, 0, 32'h0,        2'b00, 0, 0);
    vecs[13] = mkv(0, 0, 1, 0, 32'h0,        2'b00, 0, 0); // port 1 request then drop
    vecs[14] = mkv(0, 0, 0, 0, 32'h0,        2'b10, 0, 0);
    vecs[15] = mkv(0, 0, 0, 1, 32'h13579BDF, 2'b10, 0, 1);
    vecs[16] = mkv(0, 0, 0, 0, 32'h0,        2'b00, 0, 0);
    vecs[17] = mkv(0, 1, 0, 0, 32'h0,        2'b00, 0, 0); // reset while busy
    vecs[18] = mkv(0, 1, 0, 0, 32'h0,        2'b01, 0, 0);
    vecs[19] = mkv(1, 0, 0, 0, 32'h0,        2'b01, 0, 0);
    vecs[20] = mkv(0, 0, 0, 1, 32'h77777777, 2'b00, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      rst      = vecs[i].rst;
      s0_valid = vecs[i].s0v;
      s1_valid = vecs[i].s1v;
      m_ready  = vecs[i].mrdy;
      m_rdata  = vecs[i].rdata;
      @(negedge clk);
      chk("grant",    i, 32'(grant),    32'(vecs[i].e_grant));
      chk("m_valid",  i, 32'(m_valid),  32'(|vecs[i].e_grant));
      chk("s0_ready", i, 32'(s0_ready), 32'(vecs[i].e_r0));
      chk("s1_ready", i, 32'(s1_ready), 32'(vecs[i].e_r1));
      chk("m_addr",   i, m_addr,
          vecs[i].e_grant == 2'b10 ? S1_ADDR  : vecs[i].e_grant == 2'b01 ? S0_ADDR  : 32'h0);
      chk("m_wdata",  i, m_wdata,
          vecs[i].e_grant == 2'b10 ? S1_WDATA : vecs[i].e_grant == 2'b01 ? S0_WDATA : 32'h0);
      chk("m_we",     i, 32'(m_we),
          vecs[i].e_grant == 2'b10 ? 32'(S1_WE) : vecs[i].e_grant == 2'b01 ? 32'(S0_WE) : 32'h0);
      chk("s0_rdata", i, s0_rdata, vecs[i].rdata);
      chk("s1_rdata", i, s1_rdata, vecs[i].rdata);
    end

    // Continuous contention: both ports always requesting, slave answers in the first busy cycle.
    // Reset in the table above left last=1, so round-robin starts with port 0.
    done = 0; c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 40 && done < 6; cyc++) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      m_ready  = m_valid;
      rd       = 32'hA000_0000 + 32'(cyc);
      m_rdata  = rd;
      @(negedge clk);
      if (s0_ready || s1_ready) begin
        chk("rr_both_ready", done, 32'(s0_ready & s1_ready), 32'h0);
        port     = s1_ready ? 1 : 0;
        exp_port = RR_BUILD ? (done % 2) : 1;
        chk("rr_port",  done, 32'(port), 32'(exp_port));
        chk("rr_grant", done, 32'(grant), exp_port == 1 ? 32'h2 : 32'h1);
        chk("rr_rdata", done, port == 1 ? s1_rdata : s0_rdata, rd);
        if (port == 1) c1++; else c0++;
        done++;
      end
    end
    chk("rr_completions", 0, 32'(done), 32'd6);
    chk("rr_port0_count", 0, 32'(c0), RR_BUILD ? 32'd3 : 32'd0);
    chk("rr_port1_count", 0, 32'(c1), RR_BUILD ? 32'd3 : 32'd6);

    @(posedge clk);
    #1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
